// File: rtl/sp_ram_arb.sv
// sp_ram_arb: two-port round-robin arbiter in front of a single-port RAM,
// with a bounded port-1 burst lock followed by a one-cycle port-0 cooldown.
module sp_ram_arb #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOCK   = 16,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic [1:0]              req_i,
    input  logic [2*ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0]              we_i,
    input  logic [2*BE_WIDTH-1:0]   be_i,
    input  logic [2*DATA_WIDTH-1:0] wdata_i,
    input  logic                    lock_i,
    output logic [1:0]              gnt_o,
    output logic [1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [BE_WIDTH-1:0]     ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);
    typedef enum logic [1:0] {IDLE, LOCKED, COOLDOWN} state_t;
    state_t     state;
    logic       ptr;
    logic [7:0] lock_cnt;
    logic [7:0] lock_inc;
    logic       sel;
    // A lone requester always wins; contention is settled by state, then ptr.
    assign gnt_o = (&req_i) ? (state == LOCKED   ? 2'b10 :
                               state == COOLDOWN ? 2'b01 : {ptr, ~ptr}) : req_i;
    assign sel         = gnt_o[1];
    assign ram_en_o    = |gnt_o;
    assign ram_we_o    = |(gnt_o & we_i);
    assign ram_addr_o  = sel ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0];
    assign ram_be_o    = !ram_en_o ? '0 : sel ? be_i[2*BE_WIDTH-1:BE_WIDTH] : be_i[BE_WIDTH-1:0];
    assign ram_wdata_o = sel ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];
    assign rdata_o     = ram_rdata_i;
    assign lock_inc    = (lock_cnt == 8'hFF) ? lock_cnt : lock_cnt + 8'd1;
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            lock_cnt <= 8'd0;
            rvalid_o <= 2'b00;
        end else begin
            rvalid_o <= gnt_o;
            case (state)
                IDLE: if (ram_en_o) begin
                    ptr <= ~sel;
                    if (sel && lock_i) begin
                        state    <= (MAX_LOCK == 1) ? COOLDOWN : LOCKED;
                        lock_cnt <= 8'd1;
                    end
                end
                LOCKED: if (!lock_i) begin
                    state    <= IDLE;
                    ptr      <= 1'b0;
                    lock_cnt <= 8'd0;
                end else if (gnt_o[1]) begin
                    lock_cnt <= lock_inc;
                    if (lock_inc == 8'(MAX_LOCK)) state <= COOLDOWN;
                end
                // A waiting port 0 is always served here, so cooldown lasts one cycle.
                COOLDOWN: begin
                    state    <= IDLE;
                    ptr      <= 1'b1;
                    lock_cnt <= 8'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sp_ram_arb.sv
// tb_sp_ram_arb: directed checks of sp_ram_arb arbitration, lock and reset behaviour.
module tb_sp_ram_arb;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    logic            clk = 1'b0;
    logic            rstn_i;
    logic [1:0]      req_i, we_i, gnt_o, rvalid_o;
    logic [2*AW-1:0] addr_i;
    logic [2*BW-1:0] be_i;
    logic [2*DW-1:0] wdata_i;
    logic            lock_i;
    logic [DW-1:0]   rdata_o, ram_wdata_o, ram_rdata_i;
    logic            ram_en_o, ram_we_o;
    logic [AW-1:0]   ram_addr_o;
    logic [BW-1:0]   ram_be_o;
    int total = 0;
    int bad = 0;
    int g_tab [6] = '{2, 2, 2, 2, 1, 2};
    int s_tab [6] = '{0, 1, 1, 1, 2, 0};
    int c_tab [6] = '{0, 1, 2, 3, 4, 0};

    sp_ram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(4)) dut (
        .clk(clk), .rstn_i(rstn_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .be_i(be_i), .wdata_i(wdata_i), .lock_i(lock_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .ram_en_o(ram_en_o),
        .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return (a == 15'h10) ? 32'hDEADBEEF : (32'h5A000000 | {17'd0, a});
    endfunction

    always @(posedge clk) if (ram_en_o && !ram_we_o) ram_rdata_i <= ram_word(ram_addr_o);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req_i = 0; we_i = 0; be_i = 0; lock_i = 0; wdata_i = 0;
        rstn_i = 0;
        step;
        rstn_i = 1;
        step;
    endtask

    initial begin
        rstn_i = 0; req_i = 0; we_i = 0; be_i = 0; addr_i = 0; wdata_i = 0; lock_i = 0;
        #2;
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_state", dut.state, 0);
        chk("rst_ptr", dut.ptr, 0);
        chk("rst_cnt", dut.lock_cnt, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_en", ram_en_o, 0);
        step;
        rstn_i = 1;
        step;
        chk("rel_rvalid", rvalid_o, 0);

        addr_i[AW-1:0] = 15'h10; req_i = 2'b01;
        #1;
        chk("rd_gnt", gnt_o, 2'b01);
        chk("rd_en", ram_en_o, 1);
        chk("rd_addr", ram_addr_o, 15'h10);
        chk("rd_we", ram_we_o, 0);
        step;
        req_i = 0;
        chk("rd_rvalid", rvalid_o, 2'b01);
        chk("rd_rdata", rdata_o, 32'hDEADBEEF);
        chk("rd_ptr", dut.ptr, 1);
        #1;
        chk("idle_gnt", gnt_o, 0);
        chk("idle_be", ram_be_o, 0);

        do_reset;
        addr_i = {15'h24, 15'h20}; req_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_gnt", gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            step;
            chk("rr_rvalid", rvalid_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_rdata", rdata_o, ram_word((i % 2 == 0) ? 15'h20 : 15'h24));
        end
        req_i = 0;

        do_reset;
        lock_i = 1; req_i = 2'b10;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) req_i = 2'b11;
            #1;
            chk("lk_gnt", gnt_o, g_tab[i]);
            chk("lk_state", dut.state, s_tab[i]);
            chk("lk_cnt", dut.lock_cnt, c_tab[i]);
            step;
        end
        chk("lk_relock", dut.state, 1);
        req_i = 0; lock_i = 0;

        do_reset;
        lock_i = 1; req_i = 2'b10;
        #1;
        chk("eu_gnt0", gnt_o, 2'b10);
        step;
        req_i = 2'b11;
        #1;
        chk("eu_gnt1", gnt_o, 2'b10);
        chk("eu_locked", dut.state, 1);
        step;
        chk("eu_cnt2", dut.lock_cnt, 2);
        lock_i = 0;
        #1;
        chk("eu_gnt2", gnt_o, 2'b10);
        step;
        chk("eu_state", dut.state, 0);
        chk("eu_ptr", dut.ptr, 0);
        chk("eu_cnt", dut.lock_cnt, 0);
        #1;
        chk("eu_gnt3", gnt_o, 2'b01);
        step;
        req_i = 0;

        do_reset;
        lock_i = 1; req_i = 2'b10;
        step;
        req_i = 2'b11;
        step;
        step;
        chk("sx_cnt3", dut.lock_cnt, 3);
        lock_i = 0;
        #1;
        chk("sx_gnt", gnt_o, 2'b10);
        step;
        chk("sx_state", dut.state, 0);
        chk("sx_ptr", dut.ptr, 0);
        #1;
        chk("sx_gnt_next", gnt_o, 2'b01);
        step;
        req_i = 0;

        do_reset;
        addr_i[2*AW-1:AW] = 15'h40; req_i = 2'b10; we_i = 2'b10; lock_i = 1;
        be_i[2*BW-1:BW] = 4'b0011; wdata_i[2*DW-1:DW] = 32'hA5A5A5A5;
        #1;
        chk("wr_gnt", gnt_o, 2'b10);
        chk("wr_we", ram_we_o, 1);
        chk("wr_be", ram_be_o, 4'b0011);
        chk("wr_wdata", ram_wdata_o, 32'hA5A5A5A5);
        chk("wr_addr", ram_addr_o, 15'h40);
        step;
        chk("wr_rvalid", rvalid_o, 2'b10);
        chk("wr_locked", dut.state, 1);
        req_i = 0; we_i = 0; lock_i = 0; rstn_i = 0;
        #1;
        chk("wr_rst_rvalid", rvalid_o, 0);
        chk("wr_rst_state", dut.state, 0);
        chk("wr_rst_ptr", dut.ptr, 0);
        chk("wr_rst_cnt", dut.lock_cnt, 0);
        step;
        rstn_i = 1;
        step;
        chk("wr_rel_rvalid", rvalid_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sp_ram_arb.md
SP_RAM_ARB -- requirements
Module: sp_ram_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, byte-address width forwarded to the RAM wrapper.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; BE_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter MAX_LOCK, default 16, maximum consecutive port-1 grants while locked (range 1..255).
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk  input  1  clock, all state on rising edge; rstn_i  input  1  asynchronous reset, active low.
REQ-005 Requester ports, index 0 = core, 1 = accelerator:
- req_i  input  2  per-port access request
- addr_i  input  2*ADDR_WIDTH  per-port address, port n in slice n
- we_i  input  2  per-port write enable
- be_i  input  2*BE_WIDTH  per-port byte enables
- wdata_i  input  2*DATA_WIDTH  per-port write data
- lock_i  input  1  port-1 burst lock request
- gnt_o  output  2  per-port grant, one-hot or zero
- rvalid_o  output  2  per-port response valid
- rdata_o  output  DATA_WIDTH  shared read data, meaningful only with rvalid_o
REQ-006 RAM ports:
- ram_en_o  output  1  RAM enable
- ram_addr_o  output  ADDR_WIDTH  RAM address
- ram_we_o  output  1  RAM write enable
- ram_be_o  output  BE_WIDTH  RAM byte enables
- ram_wdata_o  output  DATA_WIDTH  RAM write data
- ram_rdata_i  input  DATA_WIDTH  RAM read data, valid one cycle after ram_en_o

Function
REQ-007 gnt_o SHALL be combinational from req_i, lock_i and current state; at most one bit high per cycle.
REQ-008 A transfer SHALL occur in a cycle where req_i[n] and gnt_o[n] are both high; the requester holds addr/we/be/wdata stable until granted.
REQ-009 ram_en_o SHALL equal |gnt_o; ram_addr_o, ram_we_o, ram_be_o and ram_wdata_o SHALL be the granted port's fields; when no grant, ram_en_o = 0, ram_we_o = 0, ram_be_o = 0.
REQ-010 rvalid_o[n] SHALL be high exactly one cycle after each transfer on port n, for reads and writes alike; rdata_o SHALL equal ram_rdata_i, and its value after a write is undefined.
REQ-011 A priority pointer ptr (1 bit) SHALL hold the round-robin winner: if only one port requests, it is granted; if both request, port ptr is granted.
REQ-012 After any transfer in state IDLE, ptr SHALL be set to the non-granted port index.
REQ-013 The FSM SHALL have states IDLE, LOCKED and COOLDOWN.
REQ-014 IDLE -> LOCKED SHALL occur when port 1 transfers with lock_i high; lock_cnt SHALL be set to 1.
REQ-015 In LOCKED, port 1 SHALL have absolute priority; gnt_o[0] = 0 whenever req_i[1] = 1; port 0 may be granted in cycles where req_i[1] = 0.
REQ-016 In LOCKED, each port-1 transfer SHALL increment lock_cnt, an 8-bit saturating counter.
REQ-017 LOCKED -> IDLE SHALL occur when lock_i is low at a clock edge; ptr SHALL become 0.
REQ-018 LOCKED -> COOLDOWN SHALL occur on the edge where a port-1 transfer brings lock_cnt to MAX_LOCK while lock_i is still high.
REQ-019 If both conditions hold on the same edge, the lock_i-low exit to IDLE SHALL take precedence.
REQ-020 In COOLDOWN, port 0 SHALL have absolute priority; gnt_o[1] = 0 whenever req_i[0] = 1.
REQ-021 COOLDOWN -> IDLE SHALL occur after one port-0 transfer, or after one cycle with req_i[0] = 0; ptr SHALL become 1, and lock_cnt SHALL clear to 0.
REQ-022 The FSM SHALL not enter LOCKED directly from COOLDOWN.
REQ-023 lock_i SHALL be ignored unless the FSM is in IDLE and port 1 transfers, or the FSM is already in LOCKED.
REQ-024 Requests SHALL never be dropped; an ungranted request is served in a later cycle.
REQ-025 The worst-case port-0 wait SHALL be MAX_LOCK+1 cycles.

Reset
REQ-026 On rstn_i low, asynchronously: state = IDLE, ptr = 0, lock_cnt = 0, rvalid_o = 0.
REQ-027 A response pending when reset asserts SHALL be discarded; rvalid_o SHALL stay 0 on the first edge after reset release.
REQ-028 gnt_o and ram_* SHALL follow REQ-007/REQ-009 from the reset state; requesters gate req_i during reset.

Verification
REQ-029 Single read: port 0 reads addr 0x0010 with the RAM word 0xDEADBEEF -> gnt_o = 01 in the same cycle, rvalid_o = 01 and rdata_o = 0xDEADBEEF one cycle later.
REQ-030 Contention from reset: both ports request continuously for 4 cycles -> grants 0,1,0,1 and rvalid_o alternating one cycle behind.
REQ-031 Lock timeout: MAX_LOCK = 4, port 1 requests with lock_i high and port 0 requests continuously -> port 1 is granted 4 cycles, then port 0 is granted 1 cycle (COOLDOWN), then round-robin resumes with port 1.
REQ-032 Early unlock: lock_i drops after 2 locked grants with both ports requesting -> next grant goes to port 0, state IDLE, lock_cnt = 0 after COOLDOWN is skipped.
REQ-033 Write plus reset: port 1 writes 0xA5A5A5A5 with be = 0011 -> ram_we_o = 1 and ram_be_o = 0011; assert rstn_i in the following cycle -> rvalid_o = 0, state IDLE, ptr = 0.
REQ-034 Simultaneous exit: lock_i falls on the same edge lock_cnt reaches MAX_LOCK -> FSM enters IDLE with ptr = 0, not COOLDOWN.
